simpleuart_tx_arb: RTL and testbench

Transmit-side arbiter that shares the single `simpleuart` transmit data register between `NUM_REQ` independent byte producers, such as the management CPU console, housekeeping/debug logic and user-project message sources. It grants the UART to one requester at a time with round-robin fairness and holds the grant for a whole message. It drives the UART's `reg_dat_we`/`reg_dat_di` and stalls on `reg_dat_wait`, so that messages from different sources never interleave mid-line.

---
 rtl/simpleuart_tx_arb.sv | 128 ++++++++++++
 tb/tb_simpleuart_tx_arb.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simpleuart_tx_arb.sv
// simpleuart_tx_arb: round-robin arbiter sharing the simpleuart transmit data
// register between NUM_REQ byte producers, holding the grant for a whole message.
module simpleuart_tx_arb #(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned MAX_HOLD     = 64,
    parameter int unsigned IDLE_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    input  logic                 uart_enabled,
    output logic                 uart_dat_we,
    output logic [31:0]          uart_dat_di,
    input  logic                 uart_dat_wait
);
    localparam int unsigned IDXW  = $clog2(NUM_REQ);
    localparam int unsigned HOLDW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam int unsigned IDLEW = (IDLE_TIMEOUT == 0) ? 1 : $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic {
        ST_IDLE,
        ST_OWN
    } state_t;

    state_t            state;
    logic [IDXW-1:0]   owner;
    logic [IDXW-1:0]   rr_ptr;
    logic [HOLDW-1:0]  hold_cnt;
    logic [IDLEW-1:0]  idle_cnt;

    logic [7:0]        data_arr [NUM_REQ];
    logic              owner_valid;
    logic              owner_last;
    logic              accept;
    logic              hold_hit;
    logic              idle_hit;
    logic              rel_now;
    logic              pick_found;
    logic [IDXW-1:0]   pick_idx;
    int unsigned       j;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
        assign data_arr[g] = req_data[8*g +: 8];
    end

    // Round-robin search: first valid requester at or after rr_ptr, wrapping
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        j          = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = 32'(rr_ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!pick_found && req_valid[IDXW'(j)]) begin
                pick_found = 1'b1;
                pick_idx   = IDXW'(j);
            end
        end
    end

    // Owner datapath to the UART plus acceptance and release decisions
    always_comb begin
        owner_valid = req_valid[owner];
        owner_last  = req_last[owner];
        uart_dat_we = (state == ST_OWN) && owner_valid && uart_enabled;
        uart_dat_di = uart_dat_we ? {24'b0, data_arr[owner]} : '0;
        accept      = uart_dat_we && !uart_dat_wait;
        req_ready   = accept ? grant : '0;
        // Both limits fire on the cycle whose increment would reach them
        hold_hit    = accept && (MAX_HOLD != 0) &&
                      ((32'(hold_cnt) + 32'd1) == MAX_HOLD);
        idle_hit    = !owner_valid && (IDLE_TIMEOUT != 0) &&
                      ((32'(idle_cnt) + 32'd1) == IDLE_TIMEOUT);
        rel_now     = !uart_enabled || (accept && owner_last) || hold_hit || idle_hit;
    end

    // Ownership FSM with registered grant/busy, pointer and counters
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            idle_cnt <= '0;
            grant    <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (uart_enabled && pick_found) begin
                        state    <= ST_OWN;
                        owner    <= pick_idx;
                        grant    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        busy     <= 1'b1;
                        hold_cnt <= '0;
                        idle_cnt <= '0;
                    end
                end
                ST_OWN: begin
                    if (rel_now) begin
                        state    <= ST_IDLE;
                        rr_ptr   <= (owner == IDXW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                        grant    <= '0;
                        busy     <= 1'b0;
                        hold_cnt <= '0;
                        idle_cnt <= '0;
                    end else begin
                        if (accept && (hold_cnt != '1)) begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                        if (owner_valid) begin
                            idle_cnt <= '0;
                        end else if (idle_cnt != '1) begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_simpleuart_tx_arb.sv
// tb_simpleuart_tx_arb: directed bench with a simpleuart-like transmitter,
// a serial-line decoder and a cycle-level behavioural arbiter model.
module tb_simpleuart_tx_arb;
    localparam int NREQ  = 3;
    localparam int MAXH  = 4;
    localparam int IDLET = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [2:0]  req_valid = '0;
    logic [23:0] req_data = '0;
    logic [2:0]  req_last = '0;
    logic [2:0]  req_ready;
    logic [2:0]  grant;
    logic        busy;
    logic        uart_enabled = 1'b0;
    logic        uart_dat_we;
    logic [31:0] uart_dat_di;
    logic        uart_dat_wait;

    simpleuart_tx_arb #(
        .NUM_REQ(NREQ),
        .MAX_HOLD(MAXH),
        .IDLE_TIMEOUT(IDLET)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .grant(grant),
        .busy(busy),
        .uart_enabled(uart_enabled),
        .uart_dat_we(uart_dat_we),
        .uart_dat_di(uart_dat_di),
        .uart_dat_wait(uart_dat_wait)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, got, exp);
        end
    endtask

    // Transmitter: 4 clocks per bit, start + 8 data + stop, stalls writes while busy
    logic [9:0] u_shift;
    int         u_bits;
    int         u_div;
    logic       ser_tx;
    assign uart_dat_wait = uart_dat_we && (u_bits != 0);
    assign ser_tx = (u_bits != 0) ? u_shift[0] : 1'b1;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            u_shift <= '1;
            u_bits  <= 0;
            u_div   <= 0;
        end else if (uart_dat_we && !uart_dat_wait) begin
            u_shift <= {1'b1, uart_dat_di[7:0], 1'b0};
            u_bits  <= 10;
            u_div   <= 0;
        end else if (u_bits != 0) begin
            if (u_div == 3) begin
                u_div   <= 0;
                u_shift <= {1'b1, u_shift[9:1]};
                u_bits  <= u_bits - 1;
            end else begin
                u_div <= u_div + 1;
            end
        end
    end

    // Serial decoder: bytes seen on ser_tx, frames cut by reset are dropped
    logic [7:0] rx_q[$];
    logic       rx_busy = 1'b0;
    initial begin
        logic [7:0] rb;
        logic       ok;
        forever begin
            @(negedge clk);
            if (resetn && ser_tx == 1'b0) begin
                rx_busy = 1'b1;
                ok = 1'b1;
                rb = '0;
                for (int t = 1; t <= 38; t++) begin
                    @(negedge clk);
                    if (!resetn) ok = 1'b0;
                    if (t == 2 && ser_tx != 1'b0) ok = 1'b0;
                    if (t >= 6 && t <= 34 && ((t - 6) % 4) == 0) rb[(t-6)/4] = ser_tx;
                    if (t == 38 && ser_tx != 1'b1) ok = 1'b0;
                end
                if (ok) rx_q.push_back(rb);
                rx_busy = 1'b0;
            end
        end
    end

    // Requesters: queues of {last, byte}, advanced after each observed ready
    logic [8:0] rq [3][$];
    logic [2:0] seen = '0;
    int         rdy_cnt [3];

    task automatic drive();
        for (int i = 0; i < 3; i++) begin
            if (rq[i].size() != 0) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = rq[i][0][7:0];
                req_last[i]        = rq[i][0][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (seen[i] && rq[i].size() != 0) void'(rq[i].pop_front());
            end
            drive();
        end
    end

    // Arbiter model: owner (-1 = none), pointer, bytes sent, quiet cycles
    int m_own = -1, m_ptr = 0, m_sent = 0, m_quiet = 0;
    int n_own = -1, n_ptr = 0, n_sent = 0, n_quiet = 0;
    logic [7:0] m_log[$];

    logic [2:0]  e_grant, e_ready;
    logic        e_we, e_wait, e_acc, ov, ol, rel;
    logic [7:0]  ob;
    logic [31:0] e_di;
    int          jj;

    always @(negedge clk) begin
        ov = 1'b0; ol = 1'b0; ob = 8'h00;
        if (m_own >= 0) begin
            ov = req_valid[m_own];
            ol = req_last[m_own];
            ob = req_data[8*m_own +: 8];
        end
        e_grant = (m_own >= 0) ? (3'b001 << m_own) : 3'b000;
        e_we    = (m_own >= 0) && ov && uart_enabled;
        e_wait  = e_we && (u_bits != 0);
        e_acc   = e_we && !e_wait;
        e_ready = e_acc ? e_grant : 3'b000;
        e_di    = e_we ? {24'h0, ob} : 32'h0;

        chk("grant", {29'h0, grant}, {29'h0, e_grant});
        chk("busy", {31'h0, busy}, {31'h0, (m_own >= 0)});
        chk("we", {31'h0, uart_dat_we}, {31'h0, e_we});
        chk("di", uart_dat_di, e_di);
        chk("ready", {29'h0, req_ready}, {29'h0, e_ready});

        seen = req_ready;
        for (int i = 0; i < 3; i++) rdy_cnt[i] += int'(req_ready[i]);

        n_own = m_own; n_ptr = m_ptr; n_sent = m_sent; n_quiet = m_quiet;
        if (!resetn) begin
            n_own = -1; n_ptr = 0; n_sent = 0; n_quiet = 0;
        end else if (m_own < 0) begin
            if (uart_enabled) begin
                for (int k = 0; k < NREQ; k++) begin
                    jj = (m_ptr + k) % NREQ;
                    if (n_own < 0 && req_valid[jj]) begin
                        n_own = jj; n_sent = 0; n_quiet = 0;
                    end
                end
            end
        end else begin
            if (e_acc) m_log.push_back(ob);
            rel = !uart_enabled || (e_acc && ol) || (e_acc && (m_sent + 1 == MAXH)) ||
                  (!ov && (m_quiet + 1 == IDLET));
            if (rel) begin
                n_own = -1; n_ptr = (m_own + 1) % NREQ; n_sent = 0; n_quiet = 0;
            end else begin
                n_sent  = m_sent + (e_acc ? 1 : 0);
                n_quiet = ov ? 0 : m_quiet + 1;
            end
        end
    end

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_own <= -1; m_ptr <= 0; m_sent <= 0; m_quiet <= 0;
        end else begin
            m_own <= n_own; m_ptr <= n_ptr; m_sent <= n_sent; m_quiet <= n_quiet;
        end
    end

    task automatic clear_env();
        for (int i = 0; i < 3; i++) begin
            rq[i].delete();
            rdy_cnt[i] = 0;
        end
        rx_q.delete();
        m_log.delete();
        drive();
    endtask

    task automatic do_reset(input logic en);
        resetn = 1'b0;
        uart_enabled = en;
        clear_env();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic wait_quiet(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0 &&
                     grant == 3'b000 && u_bits == 0 && !rx_busy) && n < 3000);
        chk({nm, "_quiet"}, {31'h0, (n < 3000)}, 32'h1);
    endtask

    // exp holds n bytes, first byte in the most significant used position
    task automatic check_stream(input string nm, input logic [63:0] exp, input int n);
        logic [7:0] eb;
        chk({nm, "_rx_len"}, rx_q.size(), n);
        chk({nm, "_model_len"}, m_log.size(), n);
        for (int k = 0; k < n; k++) begin
            eb = exp[8*(n-1-k) +: 8];
            if (k < rx_q.size()) chk({nm, "_rx_byte"}, {24'h0, rx_q[k]}, {24'h0, eb});
            if (k < m_log.size()) chk({nm, "_model_byte"}, {24'h0, m_log[k]}, {24'h0, eb});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t simulation did not finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // single byte from requester 1
        do_reset(1'b1);
        chk("rst_grant", {29'h0, grant}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        rq[1].push_back({1'b1, 8'h41});
        drive();
        @(negedge clk);
        chk("sb_idle_grant", {29'h0, grant}, 32'h0);
        @(negedge clk);
        chk("sb_grant", {29'h0, grant}, 32'h2);
        chk("sb_we", {31'h0, uart_dat_we}, 32'h1);
        chk("sb_di", uart_dat_di, 32'h00000041);
        chk("sb_ready", {29'h0, req_ready}, 32'h2);
        @(negedge clk);
        chk("sb_busy_after", {31'h0, busy}, 32'h0);
        wait_quiet("sb");
        chk("sb_ready_pulses", rdy_cnt[1], 1);
        check_stream("sb", 64'h41, 1);

        // round-robin with every byte a full message
        do_reset(1'b1);
        for (int r = 0; r < 2; r++) begin
            rq[0].push_back({1'b1, 8'hA0});
            rq[1].push_back({1'b1, 8'hB0});
            rq[2].push_back({1'b1, 8'hC0});
        end
        drive();
        wait_quiet("rr");
        check_stream("rr", 64'hA0B0C0A0B0C0, 6);

        // message lock against a waiting requester 2
        do_reset(1'b1);
        rq[0].push_back({1'b0, 8'h41});
        rq[0].push_back({1'b0, 8'h42});
        rq[0].push_back({1'b1, 8'h0A});
        rq[2].push_back({1'b1, 8'h5A});
        drive();
        wait_quiet("lock");
        check_stream("lock", 64'h41420A5A, 4);

        // forced release after MAX_HOLD bytes
        do_reset(1'b1);
        for (int b = 1; b <= 6; b++) rq[0].push_back({1'b0, 8'(b)});
        rq[1].push_back({1'b1, 8'h11});
        drive();
        wait_quiet("hold");
        check_stream("hold", 64'h01020304110506, 7);

        // idle timeout: last valid cycle is the acceptance cycle
        do_reset(1'b1);
        rq[0].push_back({1'b0, 8'h77});
        rq[1].push_back({1'b1, 8'h88});
        drive();
        @(negedge clk);
        chk("it_idle", {29'h0, grant}, 32'h0);
        @(negedge clk);
        chk("it_grant0", {29'h0, grant}, 32'h1);
        chk("it_ready0", {29'h0, req_ready}, 32'h1);
        repeat (7) @(negedge clk);
        @(negedge clk);
        chk("it_hold_8th", {29'h0, grant}, 32'h1);
        @(negedge clk);
        chk("it_drop", {29'h0, grant}, 32'h0);
        @(negedge clk);
        chk("it_grant1", {29'h0, grant}, 32'h2);
        wait_quiet("it");
        check_stream("it", 64'h7788, 2);

        // disabled UART, release on disable, asynchronous reset mid-stall
        do_reset(1'b0);
        rq[0].push_back({1'b1, 8'h11});
        rq[1].push_back({1'b1, 8'h22});
        drive();
        repeat (5) begin
            @(negedge clk);
            chk("dis_we", {31'h0, uart_dat_we}, 32'h0);
            chk("dis_grant", {29'h0, grant}, 32'h0);
        end
        @(posedge clk);
        #2 uart_enabled = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("en_grant0", {29'h0, grant}, 32'h1);
        @(negedge clk);
        @(negedge clk);
        chk("en_grant1", {29'h0, grant}, 32'h2);
        chk("en_stall_ready", {29'h0, req_ready}, 32'h0);
        @(posedge clk);
        #2 uart_enabled = 1'b0;
        @(negedge clk);
        chk("off_we", {31'h0, uart_dat_we}, 32'h0);
        @(negedge clk);
        chk("off_grant", {29'h0, grant}, 32'h0);
        chk("off_busy", {31'h0, busy}, 32'h0);
        @(posedge clk);
        #2 uart_enabled = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("re_grant1", {29'h0, grant}, 32'h2);
        chk("re_stall_we", {31'h0, uart_dat_we}, 32'h1);
        #3 resetn = 1'b0;
        #1;
        chk("ar_grant", {29'h0, grant}, 32'h0);
        chk("ar_busy", {31'h0, busy}, 32'h0);
        chk("ar_ready", {29'h0, req_ready}, 32'h0);
        chk("ar_we", {31'h0, uart_dat_we}, 32'h0);
        chk("ar_di", uart_dat_di, 32'h0);
        clear_env();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
